// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: scan tick and digit data in,
// active-low anode/segment/dot lines out.
interface seg7_scan_driver_if;
  logic        DividedClock;
  logic [31:0] Value;
  logic [7:0]  DigitEnable;
  logic [7:0]  DotMask;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  modport master (
    output DividedClock, Value, DigitEnable, DotMask,
    input  AN, SEG, DP
  );

  modport slave (
    input  DividedClock, Value, DigitEnable, DotMask,
    output AN, SEG, DP
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver. Each rising edge of the divider
// tick advances one digit, blanks all anodes for BLANK_CYCLES clocks to
// suppress ghosting, then drives the digit. A whole frame is taken from one
// snapshot of Value/DigitEnable/DotMask captured when the scan wraps to
// digit 0. Optional leading-zero blanking: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic               Clock,
  input logic               Reset,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned     IdxW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
  localparam logic [7:0]      LastCnt = 8'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {StWait, StBlank, StShow} state_e;

  state_e          state_q, state_d;
  logic            tick_q;
  logic [IdxW-1:0] idx_q, idx_d, idx_inc;
  logic [7:0]      cnt_q, cnt_d;
  logic [31:0]     snap_q, snap_d;
  logic [7:0]      en_snap_q, en_snap_d;
  logic [7:0]      dp_snap_q, dp_snap_d;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic            step;
  logic [3:0]      nibble;
  logic [7:0]      an_show;
  logic [6:0]      seg_show;

  // Active-low gfedcba hex font.
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Divider runs in this clock domain, so a plain edge detect suffices.
  assign step    = bus.DividedClock & ~tick_q;
  assign idx_inc = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic lead_zero;

  // Digit is a leading zero when it and every higher scanned nibble are zero.
  always_comb begin
    lead_zero = (idx_q != '0);
    for (int i = 0; i < 8; i++) begin
      if (i >= int'(idx_q) && i < int'(NUM_DIGITS) && snap_q[4*i +: 4] != 4'h0) begin
        lead_zero = 1'b0;
      end
    end
  end
`endif

  // Pattern the current digit will present once its blanking gap ends.
  always_comb begin
    nibble = 4'h0;
    for (int i = 0; i < 8; i++) begin
      if (i == int'(idx_q)) nibble = snap_q[4*i +: 4];
    end
    an_show         = 8'hFF;
    an_show[idx_q]  = ~en_snap_q[idx_q];
    seg_show        = decode(nibble);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (lead_zero) begin
      an_show  = 8'hFF;
      seg_show = 7'h7F;
    end
`endif
  end

  // Next-state: a tick always forces a fresh blanking gap for the next digit.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    en_snap_d = en_snap_q;
    dp_snap_d = dp_snap_q;
    an_d      = an_q;
    seg_d     = seg_q;
    dp_d      = dp_q;
    if (step) begin
      idx_d   = idx_inc;
      state_d = StBlank;
      cnt_d   = 8'd0;
      an_d    = 8'hFF;
      seg_d   = 7'h7F;
      dp_d    = 1'b1;
      if (idx_inc == '0) begin
        snap_d    = bus.Value;
        en_snap_d = bus.DigitEnable;
        dp_snap_d = bus.DotMask;
      end
    end else begin
      unique case (state_q)
        StWait, StShow: ;
        StBlank: begin
          if (cnt_q == LastCnt) begin
            state_d = StShow;
            an_d    = an_show;
            seg_d   = seg_show;
            dp_d    = ~dp_snap_q[idx_q];
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = StWait;
      endcase
    end
  end

  // State and registered display outputs; reset wins over a coincident tick.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= StWait;
      tick_q    <= 1'b0;
      idx_q     <= LastIdx;
      cnt_q     <= 8'd0;
      snap_q    <= 32'd0;
      en_snap_q <= 8'd0;
      dp_snap_q <= 8'd0;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      tick_q    <= bus.DividedClock;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      en_snap_q <= en_snap_d;
      dp_snap_q <= dp_snap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign bus.AN  = an_q;
  assign bus.SEG = seg_q;
  assign bus.DP  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: each tick pushes the expected
// blank and digit patterns with their due cycle; a monitor pops and checks
// whenever the display outputs change.
module tb_seg7_scan_driver;

  localparam int unsigned ND = 8;
  localparam int unsigned BC = 16;

  localparam logic [6:0] Dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                                      7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21,
                                      7'h06, 7'h0E};

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    int         cyc;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .NUM_DIGITS  (ND),
    .BLANK_CYCLES(BC)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  int   cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   rst_phase = 1'b1;
  bit   fin_req = 1'b0;
  bit   fin_ack = 1'b0;
  logic [15:0] prev = 16'hFFFF;

  // Monitor: reset-value checks while in reset, scoreboard pops afterwards.
  always @(negedge Clock) begin
    logic [15:0] cur;
    exp_t        e;
    cur = {bus.AN, bus.SEG, bus.DP};
    if (rst_phase) begin
      total++;
      if (cur !== 16'hFFFF) begin
        bad++;
        $display("FAIL reset_outputs got AN=%h SEG=%h DP=%b required AN=ff SEG=7f DP=1",
                 bus.AN, bus.SEG, bus.DP);
      end
    end else if (cur !== prev) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cyc=%0d got AN=%h SEG=%h DP=%b required no change",
                 cyc, bus.AN, bus.SEG, bus.DP);
      end else begin
        e = q.pop_front();
        if (cur !== {e.an, e.seg, e.dp}) begin
          bad++;
          $display("FAIL pattern cyc=%0d got AN=%h SEG=%h DP=%b required AN=%h SEG=%h DP=%b",
                   cyc, bus.AN, bus.SEG, bus.DP, e.an, e.seg, e.dp);
        end
        total++;
        if (cyc != e.cyc) begin
          bad++;
          $display("FAIL timing AN=%h SEG=%h got cyc=%0d required cyc=%0d",
                   e.an, e.seg, cyc, e.cyc);
        end
      end
    end
    if (fin_req && !fin_ack) begin
      total++;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL pending_expectations got %0d required 0 (next AN=%h SEG=%h cyc=%0d)",
                 q.size(), q[0].an, q[0].seg, q[0].cyc);
      end
      fin_ack = 1'b1;
    end
    prev = cur;
  end

  logic [7:0]  l_an  = 8'hFF;
  logic [6:0]  l_seg = 7'h7F;
  logic        l_dp  = 1'b1;
  int          m_idx = ND - 1;
  logic [31:0] m_snap = '0;
  logic [7:0]  m_en = '0;
  logic [7:0]  m_dot = '0;

  // Queue a pattern only when it differs from the previously expected one.
  task automatic push(input logic [7:0] an, input logic [6:0] seg, input logic dp, input int c);
    exp_t e;
    if ({an, seg, dp} != {l_an, l_seg, l_dp}) begin
      e.an = an;
      e.seg = seg;
      e.dp = dp;
      e.cyc = c;
      q.push_back(e);
      l_an = an;
      l_seg = seg;
      l_dp = dp;
    end
  endtask

  // Called just after a posedge; issues a tick and returns so the next call's
  // step lands exactly gap cycles after this one.
  task automatic tick(input int gap);
    int         e;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] nib;
    bus.DividedClock = 1'b1;
    e = cyc + 1;
    m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
    if (m_idx == 0) begin
      m_snap = bus.Value;
      m_en   = bus.DigitEnable;
      m_dot  = bus.DotMask;
    end
    push(8'hFF, 7'h7F, 1'b1, e);
    if (gap > int'(BC)) begin
      nib = m_snap[4*m_idx +: 4];
      an = 8'hFF;
      an[m_idx] = ~m_en[m_idx];
      seg = Dec[nib];
      dp = ~m_dot[m_idx];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (m_idx > 0 && (m_snap >> (4 * m_idx)) == 32'd0) begin
        an = 8'hFF;
        seg = 7'h7F;
      end
`endif
      push(an, seg, dp, e + int'(BC));
    end
    @(posedge Clock);
    #1;
    bus.DividedClock = 1'b0;
    repeat (gap - 1) @(posedge Clock);
    #1;
  endtask

  initial begin
    bus.DividedClock = 1'b0;
    bus.Value        = 32'h89ABCDEF;
    bus.DigitEnable  = 8'hFF;
    bus.DotMask      = 8'h00;

    // Reset held with the tick toggling: outputs must stay all-off.
    repeat (4) begin
      @(posedge Clock);
      #1;
      bus.DividedClock = ~bus.DividedClock;
    end
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    rst_phase = 1'b0;
    @(posedge Clock);
    #1;

    // Full frame of 89ABCDEF: digit 0 AN=fe SEG=0e ... digit 7 AN=7f SEG=00.
    repeat (8) tick(20);

    // New value mid-frame: digits 4..7 must keep the 12345678 snapshot.
    bus.Value = 32'h12345678;
    repeat (4) tick(20);
    bus.Value = 32'h00000000;
    repeat (4) tick(20);

    // Upper digits disabled, decimal point on digit 0 only.
    bus.Value       = 32'h76543210;
    bus.DigitEnable = 8'h0F;
    bus.DotMask     = 8'h01;
    repeat (8) tick(20);

    // Second tick 5 cycles after the first: digit 1 never shows.
    bus.Value       = 32'h000000A5;
    bus.DigitEnable = 8'hFF;
    bus.DotMask     = 8'h00;
    tick(20);
    tick(5);
    repeat (6) tick(20);

    // Small values, exercising leading-zero blanking when enabled.
    repeat (8) tick(20);
    bus.Value   = 32'h00000000;
    bus.DotMask = 8'h01;
    repeat (8) tick(20);

    repeat (5) @(posedge Clock);
    fin_req = 1'b1;
    wait (fin_ack);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
